// File: rtl/fc_score_streamer.sv
// Class-score stream transmitter: captures one frame of FC accumulators,
// rescales each with round-half-up and saturation, then emits them serially.
module fc_score_streamer #(
    parameter int N_CLASS    = 10,
    parameter int IN_W       = 20,
    parameter int OUT_W      = 12,
    parameter int SHIFT      = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [N_CLASS*IN_W-1:0]  acc_in,
    output logic [OUT_W-1:0]         data_out,
    output logic                     valid_out,
    output logic [3:0]               class_idx,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic signed [IN_W:0] RND_HALF = (IN_W+1)'((2**SHIFT) / 2);
    localparam logic signed [IN_W:0] SAT_MAX  = (IN_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [IN_W:0] SAT_MIN  = (IN_W+1)'(-(2**(OUT_W-1)));

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCALE,
        S_SEND,
        S_GAP
    } state_t;

    function automatic logic signed [IN_W:0] round_shift(input logic signed [IN_W-1:0] a);
        logic signed [IN_W:0] ext;
        ext = {a[IN_W-1], a};
        return (ext + RND_HALF) >>> SHIFT;
    endfunction

    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [IN_W:0] t);
        logic signed [OUT_W-1:0] r;
        if (t > SAT_MAX) begin
            r = SAT_MAX[OUT_W-1:0];
        end else if (t < SAT_MIN) begin
            r = SAT_MIN[OUT_W-1:0];
        end else begin
            r = t[OUT_W-1:0];
        end
        return r;
    endfunction

    state_t                   r_state;
    logic [3:0]               r_idx;
    logic [GAP_W-1:0]         r_gap_cnt;
    logic signed [IN_W-1:0]   r_acc_p0 [N_CLASS];
    logic signed [OUT_W-1:0]  r_buf_p1 [N_CLASS];
    logic signed [OUT_W-1:0]  r_data_p2;
    logic                     r_vld_p2;
    logic [3:0]               r_cls_p2;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_overrun;

    logic w_accept;
    logic w_last_cls;
    logic w_gap_end;

    assign w_accept   = (r_state == S_IDLE) && load;
    assign w_last_cls = (r_idx == 4'(N_CLASS - 1));
    assign w_gap_end  = (r_gap_cnt == GAP_W'(GAP_CYCLES - 1));

    // p0: frame capture; p1: scaled score buffer (datapath, no reset)
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int k = 0; k < N_CLASS; k++) begin
                r_acc_p0[k] <= acc_in[k*IN_W +: IN_W];
            end
        end
        if (r_state == S_SCALE) begin
            for (int k = 0; k < N_CLASS; k++) begin
                r_buf_p1[k] <= saturate(round_shift(r_acc_p0[k]));
            end
        end
    end

    // p2: serializer FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_gap_cnt <= '0;
            r_data_p2 <= '0;
            r_vld_p2  <= 1'b0;
            r_cls_p2  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_overrun <= load && (r_state != S_IDLE);
            r_vld_p2  <= 1'b0;
            r_data_p2 <= '0;
            r_cls_p2  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_state <= S_SCALE;
                        r_busy  <= 1'b1;
                    end
                end
                S_SCALE: begin
                    r_state <= S_SEND;
                    r_idx   <= '0;
                end
                S_SEND: begin
                    r_data_p2 <= r_buf_p1[r_idx];
                    r_cls_p2  <= r_idx;
                    r_vld_p2  <= 1'b1;
                    r_idx     <= r_idx + 4'd1;
                    if (w_last_cls) begin
                        r_state   <= S_GAP;
                        r_gap_cnt <= '0;
                    end
                end
                S_GAP: begin
                    r_done <= (r_gap_cnt == '0);
                    if (w_gap_end) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out  = r_data_p2;
    assign valid_out = r_vld_p2;
    assign class_idx = r_cls_p2;
    assign busy      = r_busy;
    assign done      = r_done;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_fc_score_streamer.sv
// Bench for fc_score_streamer: frame-timeline reference model checked every
// cycle, plus table-driven scaling vectors and directed corner sequences.
module tb_fc_score_streamer;

    localparam int N_CLASS    = 10;
    localparam int IN_W       = 20;
    localparam int OUT_W      = 12;
    localparam int SHIFT      = 4;
    localparam int GAP_CYCLES = 8;
    localparam int PERIOD     = N_CLASS + 2 + GAP_CYCLES;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    load;
    logic [N_CLASS*IN_W-1:0] acc_in;
    logic [OUT_W-1:0]        data_out;
    logic                    valid_out;
    logic [3:0]              class_idx;
    logic                    busy;
    logic                    done;
    logic                    overrun;

    always #5 clk = ~clk;

    fc_score_streamer #(
        .N_CLASS(N_CLASS), .IN_W(IN_W), .OUT_W(OUT_W),
        .SHIFT(SHIFT), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .acc_in(acc_in),
        .data_out(data_out), .valid_out(valid_out), .class_idx(class_idx),
        .busy(busy), .done(done), .overrun(overrun)
    );

    typedef struct {
        int acc;
        int exp;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    // Reference model: a frame is a window of edges relative to its acceptance edge.
    int  edge_n   = 0;
    bit  m_active = 0;
    int  m_start  = 0;
    int  m_free   = 0;
    int  m_score [N_CLASS];
    int  acc_vals [N_CLASS];
    int  obs_q [$];
    int  vld_starts [$];
    bit  prev_valid = 0;
    int  ov_cnt   = 0;
    int  done_cnt = 0;

    function automatic int ref_score(input int a);
        longint n, dv, q;
        longint hi, lo;
        dv = longint'(2**SHIFT);
        n  = longint'(a) + dv / 2;
        q  = n / dv;
        if ((n % dv) != 0 && n < 0) q = q - 1;
        hi = longint'(2**(OUT_W-1) - 1);
        lo = -longint'(2**(OUT_W-1));
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        return int'(q);
    endfunction

    function automatic int rnd_acc();
        logic [IN_W-1:0] u;
        int r;
        u = IN_W'($urandom);
        case ($urandom % 4)
            0: r = int'($signed(u));
            1: r = int'($urandom_range(80)) - 40;
            2: r = 32700 + int'($urandom_range(100));
            default: r = -32800 + int'($urandom_range(100));
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%0d expected=%0d", name, edge_n, act, exp);
        end
    endtask

    task automatic randomize_acc();
        for (int k = 0; k < N_CLASS; k++) acc_vals[k] = rnd_acc();
    endtask

    task automatic step(input bit r, input bit ld);
        int  d;
        bit  e_ov, e_vld, e_done, e_busy;
        int  e_data, e_idx;
        logic [IN_W-1:0] tmp;
        rst  = r;
        load = ld;
        for (int k = 0; k < N_CLASS; k++) begin
            tmp = acc_vals[k][IN_W-1:0];
            acc_in[k*IN_W +: IN_W] = tmp;
        end
        @(posedge clk);
        edge_n++;
        e_ov = 0;
        if (r) begin
            m_active = 0;
            m_free   = edge_n + 1;
        end else begin
            e_ov = ld && m_active && (edge_n < m_free);
            if (ld && (!m_active || edge_n >= m_free)) begin
                m_active = 1;
                m_start  = edge_n;
                m_free   = edge_n + PERIOD;
                for (int k = 0; k < N_CLASS; k++) m_score[k] = ref_score(acc_vals[k]);
            end
        end
        d      = edge_n - m_start;
        e_vld  = m_active && d >= 2 && d <= N_CLASS + 1;
        e_done = m_active && d == N_CLASS + 2;
        e_busy = m_active && d <= N_CLASS + GAP_CYCLES;
        e_data = e_vld ? m_score[d-2] : 0;
        e_idx  = e_vld ? d - 2 : 0;
        #1;
        chk("valid_out", longint'(valid_out), longint'(e_vld));
        chk("data_out",  longint'($signed(data_out)), longint'(e_data));
        chk("class_idx", longint'(class_idx), longint'(e_idx));
        chk("busy",      longint'(busy), longint'(e_busy));
        chk("done",      longint'(done), longint'(e_done));
        chk("overrun",   longint'(overrun), longint'(e_ov));
        if (valid_out) obs_q.push_back(int'($signed(data_out)));
        if (valid_out && !prev_valid) vld_starts.push_back(edge_n);
        prev_valid = valid_out;
        if (overrun) ov_cnt++;
        if (done) done_cnt++;
    endtask

    vec_t tbl [20];
    int   saved_exp [N_CLASS];

    initial begin
        tbl[0]  = '{40, 3};        tbl[1]  = '{-24, -1};
        tbl[2]  = '{-8, 0};        tbl[3]  = '{524287, 2047};
        tbl[4]  = '{-524288, -2048}; tbl[5] = '{8, 1};
        tbl[6]  = '{7, 0};         tbl[7]  = '{-9, -1};
        tbl[8]  = '{32760, 2047};  tbl[9]  = '{32751, 2047};
        tbl[10] = '{-32776, -2048}; tbl[11] = '{-32792, -2048};
        tbl[12] = '{0, 0};         tbl[13] = '{24, 2};
        tbl[14] = '{-7, 0};        tbl[15] = '{-25, -2};
        tbl[16] = '{1608, 101};    tbl[17] = '{-1608, -100};
        tbl[18] = '{32744, 2047};  tbl[19] = '{-32760, -2047};

        rst = 1'b1;
        load = 1'b0;
        acc_in = '0;
        for (int k = 0; k < N_CLASS; k++) acc_vals[k] = 0;

        // Reset with load held, then release
        repeat (3) step(1, 1);
        repeat (4) step(0, 0);
        chk("t1_busy_idle", longint'(busy), 0);
        chk("t1_valid_idle", longint'(valid_out), 0);

        // Ramp frame: 16k+8 rounds up to k+1
        for (int k = 0; k < N_CLASS; k++) acc_vals[k] = 16*k + 8;
        obs_q.delete();
        step(0, 1);
        repeat (PERIOD) step(0, 0);
        chk("t2_count", obs_q.size(), N_CLASS);
        for (int k = 0; k < N_CLASS && k < obs_q.size(); k++) chk("t2_score", obs_q[k], k + 1);

        // Table-driven scaling vectors, ten per frame
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < N_CLASS; k++) acc_vals[k] = tbl[f*N_CLASS + k].acc;
            obs_q.delete();
            step(0, 1);
            repeat (PERIOD) step(0, 0);
            chk("tbl_count", obs_q.size(), N_CLASS);
            for (int k = 0; k < N_CLASS && k < obs_q.size(); k++)
                chk("tbl_score", obs_q[k], tbl[f*N_CLASS + k].exp);
        end

        // Loads mid-SEND and in the last GAP cycle are ignored; acc_in churns
        randomize_acc();
        for (int k = 0; k < N_CLASS; k++) saved_exp[k] = ref_score(acc_vals[k]);
        obs_q.delete();
        ov_cnt = 0;
        step(0, 1);
        for (int d = 1; d <= N_CLASS + 1 + GAP_CYCLES; d++) begin
            randomize_acc();
            step(0, (d == 6) || (d == N_CLASS + 1 + GAP_CYCLES));
        end
        chk("t4_overrun_cnt", ov_cnt, 2);
        chk("t4_count", obs_q.size(), N_CLASS);
        for (int k = 0; k < N_CLASS && k < obs_q.size(); k++) chk("t4_score", obs_q[k], saved_exp[k]);
        step(0, 1);
        chk("t4_next_accept_busy", longint'(busy), 1);
        repeat (PERIOD) step(0, 0);

        // Reset on the fifth valid cycle
        randomize_acc();
        done_cnt = 0;
        step(0, 1);
        repeat (5) step(0, 0);
        step(1, 0);
        chk("t5_valid_dropped", longint'(valid_out), 0);
        repeat (PERIOD) step(0, 0);
        chk("t5_no_done", done_cnt, 0);
        randomize_acc();
        for (int k = 0; k < N_CLASS; k++) saved_exp[k] = ref_score(acc_vals[k]);
        obs_q.delete();
        step(0, 1);
        repeat (PERIOD) step(0, 0);
        chk("t5_count", obs_q.size(), N_CLASS);
        for (int k = 0; k < N_CLASS && k < obs_q.size(); k++) chk("t5_score", obs_q[k], saved_exp[k]);

        // Load tied high: back-to-back frames
        vld_starts.delete();
        for (int i = 0; i < 3*PERIOD + 2; i++) begin
            randomize_acc();
            step(0, 1);
        end
        repeat (PERIOD) step(0, 0);
        chk("t6_bursts", vld_starts.size(), 4);
        for (int i = 1; i < vld_starts.size(); i++)
            chk("t6_burst_spacing", vld_starts[i] - vld_starts[i-1], PERIOD);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            randomize_acc();
            step(($urandom % 100) == 0, ($urandom % 6) == 0);
        end
        repeat (PERIOD) step(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fc_score_streamer.md
Name: fc_score_streamer

Overview:
Transmitter side of the class-score stream consumed by the final decision comparator.
- Accepts one frame of N_CLASS parallel fully-connected accumulator results on a load strobe.
- Rescales each result with rounding and saturation to OUT_W-bit signed.
- Emits the scores serially, one per clock, class 0 first, with valid_out high for exactly N_CLASS consecutive cycles.
- Then holds valid_out low for a guard gap so the downstream comparator can finish its decision pipeline.

Parameters:
N_CLASS, 10, number of class scores per frame
IN_W, 20, width of each signed accumulator input
OUT_W, 12, width of each signed output score
SHIFT, 4, arithmetic right shift applied before saturation (0..IN_W-1)
GAP_CYCLES, 8, minimum valid-low cycles after the last score before the next frame is accepted (>=1)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
load  in  1  frame strobe; sampled only in IDLE
acc_in  in  N_CLASS*IN_W  signed accumulators; class k at bits [k*IN_W +: IN_W]
data_out  out  OUT_W  signed score of current class
valid_out  out  1  data_out valid this cycle
class_idx  out  4  class index of data_out (0..N_CLASS-1)
busy  out  1  frame in progress (SCALE, SEND or GAP)
done  out  1  one-cycle pulse after the last score
overrun  out  1  one-cycle pulse when load is high while busy

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE; data_out=0, valid_out=0, class_idx=0, busy=0, done=0, overrun=0.
  - Any frame in progress is discarded; score buffer contents are don't-care.
  - rst has priority over load.
- All outputs are registered. When valid_out=0, data_out=0 and class_idx=0.
- States:
  - IDLE: load=1 at edge E0 captures acc_in into the input registers; goes to SCALE; busy=1 from E0.
  - SCALE: at E1, all N_CLASS scaled scores are written to the score buffer; goes to SEND with idx=0.
  - SEND: from E2, each edge drives data_out=buf[idx], class_idx=idx, valid_out=1, then increments idx. After the edge driving idx=N_CLASS-1, goes to GAP. valid_out is high for cycles E2..E(N_CLASS+1) with no bubbles.
  - GAP: at the first GAP edge, valid_out=0 and done=1 for exactly one cycle. The block stays in GAP for GAP_CYCLES edges, then goes to IDLE with busy=0 on that edge.
- Latency:
  - Load sampled at E0 gives the first valid score registered at E2.
  - The next load can be accepted no earlier than E(N_CLASS+2+GAP_CYCLES).
- Scaling per class, in IN_W+1-bit signed arithmetic:
  - If SHIFT>0: t = (acc + 2^(SHIFT-1)) >>> SHIFT, i.e. round half toward +inf.
  - If SHIFT=0: t = acc.
  - Saturation: t > 2^(OUT_W-1)-1 gives 2^(OUT_W-1)-1; t < -2^(OUT_W-1) gives -2^(OUT_W-1); otherwise t is truncated to OUT_W bits.
- Boundary conditions:
  - load while busy (SCALE/SEND/GAP): ignored; overrun=1 for that cycle; the in-flight frame is unaffected.
  - load on the same edge the block returns from GAP to IDLE: ignored, with overrun pulsed, because the state was still GAP when sampled.
  - load held high continuously: one frame is accepted per IDLE visit; overrun pulses every busy cycle.
  - acc_in changing after E0: no effect on the current frame.
  - rst during SEND: valid_out drops on that edge, no done pulse, the remaining scores are never sent.
  - idx counter width is 4 bits; N_CLASS must be 2..16.

Test Plan:
1. Reset with load=1 held, then release rst and load -> all outputs 0, busy=0, no frame started.
2. Defaults, load once with acc_k = 16*k+8 (k=0..9) -> valid_out for 10 consecutive cycles starting 2 edges after load; data_out = 1,2,...,10 (rounding 8/16 up); class_idx = 0..9; done pulses on the next cycle; busy falls 8 cycles later.
3. acc = 40, -24, -8, 0x7FFFF, -524288 in classes 0..4 -> data_out = 3, -1, 0, 2047, -2048.
4. Second load pulsed mid-SEND and again in the last GAP cycle -> overrun pulses in both cycles; stream and data are identical to the single-frame case; the next load after busy=0 is accepted.
5. rst asserted on the 5th valid cycle -> valid_out=0 at that edge; no done; a later load yields a complete fresh 10-score frame.
6. Back-to-back frames with load tied high -> valid bursts of 10 separated by exactly GAP_CYCLES+2 invalid cycles; the second frame carries acc_in values sampled at its own acceptance edge.
